// File: rtl/encoder_output_buffer.sv
// Ping-pong output buffer for encoder_top_parallel: captures (xk, zk, zk') triples of a code block
// into one of two banks and replays each finished block as a byte stream with ready/valid backpressure.
module encoder_output_buffer #(
   parameter int ADDR_W    = 10,
   parameter int LEN_SMALL = 132,
   parameter int LEN_LARGE = 768
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       in_valid,
   input  logic       in_blocksize,
   input  logic [7:0] xk_in,
   input  logic [7:0] zk_in,
   input  logic [7:0] zk_prime_in,
   output logic       enc_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_sop,
   output logic       out_eop,
   output logic [1:0] out_lane,
   output logic       out_blocksize,
   output logic       overflow
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_SMALL = ADDR_W'(LEN_SMALL - 1);
   localparam logic [ADDR_W-1:0] LAST_LARGE = ADDR_W'(LEN_LARGE - 1);

   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
   typedef struct packed {
      logic [7:0] data;
      logic [1:0] lane;
      logic       sop;
      logic       eop;
   } beat_t;

   logic [7:0] ram_x  [0:1][0:DEPTH-1];
   logic [7:0] ram_z  [0:1][0:DEPTH-1];
   logic [7:0] ram_zp [0:1][0:DEPTH-1];
   logic [7:0] ram_q;

   bank_state_t state   [0:1];
   bank_state_t state_n [0:1];
   logic        bank_bs [0:1];

   logic              wr_sel, rd_sel, wr_sel_n, rd_sel_n;
   logic [ADDR_W-1:0] wr_addr, rd_addr, wr_last, rd_last;
   logic [1:0]        rd_lane;
   logic              issue_done;
   logic              r_valid, r_sop, r_eop;
   logic [1:0]        r_lane;
   logic              skid_valid;
   beat_t             out_beat, skid_beat, r_beat;
   logic              wr_en, wr_done, pop, eop_pop, stay_o, stay_s, room;
   logic              can_issue, issue, issue_last, enc_ready_n;

   assign r_beat        = {ram_q, r_lane, r_sop, r_eop};
   assign out_data      = out_beat.data;
   assign out_lane      = out_beat.lane;
   assign out_sop       = out_beat.sop;
   assign out_eop       = out_beat.eop;

   assign wr_en      = in_valid && (state[wr_sel] == EMPTY || state[wr_sel] == FILLING);
   // An EMPTY bank takes its length from the incoming first triple, not the stale stored blocksize
   assign wr_last    = ((state[wr_sel] == EMPTY) ? in_blocksize : bank_bs[wr_sel]) ? LAST_LARGE : LAST_SMALL;
   assign wr_done    = wr_en && (wr_addr == wr_last);
   assign rd_last    = bank_bs[rd_sel] ? LAST_LARGE : LAST_SMALL;
   assign pop        = out_valid && out_ready;
   assign eop_pop    = pop && out_beat.eop;

   // Output reg + skid form a 2-entry queue; a read is issued only if its data is sure to find a slot
   assign stay_o     = pop ? skid_valid : out_valid;
   assign stay_s     = !pop && skid_valid;
   assign room       = !(stay_o && (stay_s || r_valid));
   assign can_issue  = (state[rd_sel] == FULL) || (state[rd_sel] == DRAINING && !issue_done);
   assign issue      = can_issue && room;
   assign issue_last = issue && (rd_lane == 2'd2) && (rd_addr == rd_last);

   // Write and read sides always touch different banks, so their updates never collide
   always_comb begin
      state_n = state;
      if (wr_en)
         state_n[wr_sel] = wr_done ? FULL : FILLING;
      if (state[rd_sel] == FULL)
         state_n[rd_sel] = DRAINING;
      if (eop_pop)
         state_n[rd_sel] = EMPTY;
      wr_sel_n    = wr_sel ^ wr_done;
      rd_sel_n    = rd_sel ^ eop_pop;
      enc_ready_n = (state_n[wr_sel_n] == EMPTY) || (state_n[wr_sel_n] == FILLING);
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         ram_x[wr_sel][wr_addr]  <= xk_in;
         ram_z[wr_sel][wr_addr]  <= zk_in;
         ram_zp[wr_sel][wr_addr] <= zk_prime_in;
      end
      if (issue) begin
         case (rd_lane)
            2'd0:    ram_q <= ram_x[rd_sel][rd_addr];
            2'd1:    ram_q <= ram_z[rd_sel][rd_addr];
            default: ram_q <= ram_zp[rd_sel][rd_addr];
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= '{EMPTY, EMPTY};
         bank_bs       <= '{1'b0, 1'b0};
         wr_sel        <= 1'b0;
         rd_sel        <= 1'b0;
         wr_addr       <= '0;
         rd_addr       <= '0;
         rd_lane       <= 2'd0;
         issue_done    <= 1'b0;
         r_valid       <= 1'b0;
         r_lane        <= 2'd0;
         r_sop         <= 1'b0;
         r_eop         <= 1'b0;
         skid_valid    <= 1'b0;
         skid_beat     <= '0;
         out_beat      <= '0;
         out_valid     <= 1'b0;
         out_blocksize <= 1'b0;
         overflow      <= 1'b0;
         enc_ready     <= 1'b1;
      end else begin
         state     <= state_n;
         wr_sel    <= wr_sel_n;
         rd_sel    <= rd_sel_n;
         enc_ready <= enc_ready_n;

         if (wr_en) begin
            if (state[wr_sel] == EMPTY)
               bank_bs[wr_sel] <= in_blocksize;
            wr_addr <= wr_done ? '0 : wr_addr + 1'b1;
         end
         if (in_valid && !wr_en)
            overflow <= 1'b1;

         if (state[rd_sel] == FULL)
            out_blocksize <= bank_bs[rd_sel];

         r_valid <= issue;
         if (issue) begin
            r_lane <= rd_lane;
            r_sop  <= (rd_lane == 2'd0) && (rd_addr == '0);
            r_eop  <= issue_last;
            if (rd_addr == rd_last) begin
               rd_addr <= '0;
               rd_lane <= (rd_lane == 2'd2) ? 2'd0 : rd_lane + 2'd1;
            end else begin
               rd_addr <= rd_addr + 1'b1;
            end
         end
         if (issue_last)
            issue_done <= 1'b1;
         else if (eop_pop)
            issue_done <= 1'b0;

         // The head register only changes on a pop or while empty, keeping outputs stable under stall
         if (pop) begin
            if (skid_valid) begin
               out_beat <= skid_beat;
               if (r_valid)
                  skid_beat <= r_beat;
               else
                  skid_valid <= 1'b0;
            end else if (r_valid) begin
               out_beat <= r_beat;
            end else begin
               out_valid    <= 1'b0;
               out_beat.sop <= 1'b0;
               out_beat.eop <= 1'b0;
            end
         end else if (!out_valid) begin
            if (r_valid) begin
               out_beat  <= r_beat;
               out_valid <= 1'b1;
            end
         end else if (r_valid) begin
            skid_beat  <= r_beat;
            skid_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_encoder_output_buffer.sv
// Directed bench for encoder_output_buffer: feeds whole code blocks and checks the replayed byte stream,
// latency, backpressure stability, ping-pong overlap, blocksize sampling and mid-drain reset.
module tb_encoder_output_buffer;

   localparam int LS = 132;
   localparam int LL = 768;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_blocksize = 1'b0;
   logic [7:0] xk_in = 8'd0;
   logic [7:0] zk_in = 8'd0;
   logic [7:0] zk_prime_in = 8'd0;
   logic       enc_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       out_sop;
   logic       out_eop;
   logic [1:0] out_lane;
   logic       out_blocksize;
   logic       overflow;

   encoder_output_buffer dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_blocksize(in_blocksize),
      .xk_in(xk_in), .zk_in(zk_in), .zk_prime_in(zk_prime_in), .enc_ready(enc_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
      .out_eop(out_eop), .out_lane(out_lane), .out_blocksize(out_blocksize), .overflow(overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] data;
      logic [1:0] lane;
      logic       sop;
      logic       eop;
      logic       bs;
      int         cyc;
   } rec_t;

   rec_t       q[$];
   rec_t       mon_rec;
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         stall_bad = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data;
   logic [1:0] prev_lane;
   logic       prev_sop, prev_eop;
   logic       rand_mode = 1'b0;
   logic       ready_level = 1'b1;

   // Records every accepted byte and flags any output change while a byte is stalled
   always @(negedge clock) begin
      cyc++;
      if (!reset && prev_stall &&
          !(out_valid === 1'b1 && out_data === prev_data && out_lane === prev_lane &&
            out_sop === prev_sop && out_eop === prev_eop))
         stall_bad++;
      if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
         mon_rec.data = out_data;
         mon_rec.lane = out_lane;
         mon_rec.sop  = out_sop;
         mon_rec.eop  = out_eop;
         mon_rec.bs   = out_blocksize;
         mon_rec.cyc  = cyc;
         q.push_back(mon_rec);
      end
      prev_stall = !reset && out_valid === 1'b1 && out_ready === 1'b0;
      prev_data  = out_data;
      prev_lane  = out_lane;
      prev_sop   = out_sop;
      prev_eop   = out_eop;
   end

   always @(posedge clock) begin
      #1;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
   end

   function automatic logic [7:0] exp_byte(int i, int lane, int tag);
      return 8'(i + lane * 64 + tag);
   endfunction

   task automatic apply_reset();
      @(posedge clock); #1;
      reset = 1'b1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      q.delete();
      stall_bad = 0;
   endtask

   // Drives n triples; when drop is set, in_valid falls right after the edge that writes the last one
   task automatic send_block(input int tag, input logic bs, input int n, input bit toggle, input bit drop);
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         in_valid     = 1'b1;
         in_blocksize = (toggle && i > 0) ? logic'(i % 2) : bs;
         xk_in        = exp_byte(i, 0, tag);
         zk_in        = exp_byte(i, 1, tag);
         zk_prime_in  = exp_byte(i, 2, tag);
      end
      if (drop) begin
         @(posedge clock); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_bytes(input int n, input int budget);
      for (int c = 0; c < budget && q.size() < n; c++)
         @(negedge clock);
   endtask

   // Scans the recorded stream against consecutive blocks of length L tagged tag0 then tag1
   task automatic scan_stream(input int len, input int tag0, input int tag1, input logic bs,
                              output int errs, output int first_bad);
      errs = 0;
      first_bad = -1;
      for (int k = 0; k < q.size(); k++) begin
         int n    = k % (3 * len);
         int lane = n / len;
         int i    = n % len;
         int tag  = (k < 3 * len) ? tag0 : tag1;
         if (q[k].data !== exp_byte(i, lane, tag) || q[k].lane !== 2'(lane) ||
             q[k].sop !== (n == 0) || q[k].eop !== (n == 3 * len - 1) || q[k].bs !== bs) begin
            if (first_bad < 0) first_bad = k;
            errs++;
         end
      end
   endtask

   task automatic test_reset();
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      total++; if (out_valid !== 1'b0)     begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (out_sop !== 1'b0)       begin bad++; $display("[TB] FAIL reset_out_sop got=%b want=0", out_sop); end
      total++; if (out_eop !== 1'b0)       begin bad++; $display("[TB] FAIL reset_out_eop got=%b want=0", out_eop); end
      total++; if (overflow !== 1'b0)      begin bad++; $display("[TB] FAIL reset_overflow got=%b want=0", overflow); end
      total++; if (out_blocksize !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_blocksize got=%b want=0", out_blocksize); end
      total++; if (out_data !== 8'h00)     begin bad++; $display("[TB] FAIL reset_out_data got=%h want=00", out_data); end
      total++; if (out_lane !== 2'd0)      begin bad++; $display("[TB] FAIL reset_out_lane got=%0d want=0", out_lane); end
      total++; if (enc_ready !== 1'b1)     begin bad++; $display("[TB] FAIL reset_enc_ready got=%b want=1", enc_ready); end
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_small_block();
      logic v0, v1, v2, s2;
      int errs, first_bad;
      apply_reset();
      ready_level = 1'b1;
      send_block(0, 1'b0, LS, 1'b0, 1'b1);
      @(negedge clock); v0 = out_valid;
      @(negedge clock); v1 = out_valid;
      @(negedge clock); v2 = out_valid; s2 = out_sop;
      total++; if ({v0, v1, v2, s2} !== 4'b0011) begin bad++; $display("[TB] FAIL small_latency got=%b%b%b sop=%b want=001 sop=1", v0, v1, v2, s2); end
      wait_bytes(3 * LS, 2000);
      total++; if (q.size() !== 3 * LS) begin bad++; $display("[TB] FAIL small_count got=%0d want=%0d", q.size(), 3 * LS); end
      scan_stream(LS, 0, 0, 1'b0, errs, first_bad);
      total++; if (errs !== 0) begin bad++; $display("[TB] FAIL small_stream bad_bytes=%0d first=%0d want=0", errs, first_bad); end
      repeat (4) @(negedge clock);
      total++; if ({out_valid, enc_ready} !== 2'b01) begin bad++; $display("[TB] FAIL small_idle valid,ready got=%b%b want=01", out_valid, enc_ready); end
   endtask

   task automatic test_blocksize_sampling();
      int errs, first_bad;
      apply_reset();
      send_block(8'h21, 1'b0, LS, 1'b1, 1'b1);
      wait_bytes(3 * LS, 2000);
      repeat (10) @(negedge clock);
      total++; if (q.size() !== 3 * LS) begin bad++; $display("[TB] FAIL bs_sample_count got=%0d want=%0d", q.size(), 3 * LS); end
      scan_stream(LS, 8'h21, 8'h21, 1'b0, errs, first_bad);
      total++; if (errs !== 0) begin bad++; $display("[TB] FAIL bs_sample_stream bad_bytes=%0d first=%0d want=0", errs, first_bad); end
   endtask

   task automatic test_random_ready();
      int errs, first_bad;
      apply_reset();
      rand_mode = 1'b1;
      send_block(8'h05, 1'b1, LL, 1'b0, 1'b1);
      wait_bytes(3 * LL, 20000);
      rand_mode = 1'b0;
      total++; if (q.size() !== 3 * LL) begin bad++; $display("[TB] FAIL large_count got=%0d want=%0d", q.size(), 3 * LL); end
      scan_stream(LL, 8'h05, 8'h05, 1'b1, errs, first_bad);
      total++; if (errs !== 0) begin bad++; $display("[TB] FAIL large_stream bad_bytes=%0d first=%0d want=0", errs, first_bad); end
      total++; if (stall_bad !== 0) begin bad++; $display("[TB] FAIL large_stall_stable changes=%0d want=0", stall_bad); end
   endtask

   task automatic test_back_to_back();
      int errs, first_bad, gap;
      apply_reset();
      ready_level = 1'b1;
      send_block(8'h00, 1'b0, LS, 1'b0, 1'b0);
      send_block(8'h10, 1'b0, LS, 1'b0, 1'b1);
      @(negedge clock);
      total++; if (enc_ready !== 1'b0) begin bad++; $display("[TB] FAIL pp_enc_ready_low got=%b want=0", enc_ready); end
      send_block(8'h20, 1'b0, 5, 1'b0, 1'b1);
      @(negedge clock);
      total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL pp_overflow got=%b want=1", overflow); end
      wait_bytes(6 * LS, 3000);
      repeat (10) @(negedge clock);
      total++; if (q.size() !== 6 * LS) begin bad++; $display("[TB] FAIL pp_count got=%0d want=%0d", q.size(), 6 * LS); end
      scan_stream(LS, 8'h00, 8'h10, 1'b0, errs, first_bad);
      total++; if (errs !== 0) begin bad++; $display("[TB] FAIL pp_stream bad_bytes=%0d first=%0d want=0", errs, first_bad); end
      gap = (q.size() > 3 * LS) ? q[3 * LS].cyc - q[3 * LS - 1].cyc : -1;
      total++; if (gap !== 3) begin bad++; $display("[TB] FAIL pp_gap cycles_between_eop_sop=%0d want=3", gap); end
      total++; if (enc_ready !== 1'b1) begin bad++; $display("[TB] FAIL pp_enc_ready_high got=%b want=1", enc_ready); end
   endtask

   // Runs straight after the overlap test so the sticky overflow is still set going in
   task automatic test_reset_mid_drain();
      int errs, first_bad;
      q.delete();
      ready_level = 1'b1;
      send_block(8'h33, 1'b1, LL, 1'b0, 1'b1);
      wait_bytes(200, 2000);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_out_valid got=%b want=0", out_valid); end
      total++; if (enc_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_enc_ready got=%b want=1", enc_ready); end
      total++; if (overflow !== 1'b0)  begin bad++; $display("[TB] FAIL mid_reset_overflow got=%b want=0", overflow); end
      @(posedge clock); #1;
      reset = 1'b0;
      q.delete();
      stall_bad = 0;
      send_block(8'h50, 1'b0, LS, 1'b0, 1'b1);
      wait_bytes(3 * LS, 2000);
      repeat (10) @(negedge clock);
      total++; if (q.size() !== 3 * LS) begin bad++; $display("[TB] FAIL post_reset_count got=%0d want=%0d", q.size(), 3 * LS); end
      scan_stream(LS, 8'h50, 8'h50, 1'b0, errs, first_bad);
      total++; if (errs !== 0) begin bad++; $display("[TB] FAIL post_reset_stream bad_bytes=%0d first=%0d want=0", errs, first_bad); end
   endtask

   initial begin
      test_reset();
      test_small_block();
      test_blocksize_sampling();
      test_random_ready();
      test_back_to_back();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
